// File: rtl/glyph_streamer.sv
// Text-buffer glyph streamer: serially loaded character buffer, scanned row by
// row through an external combinational character ROM with registered row output.
module glyph_streamer #(
  parameter int WORD_COUNT = 32,
  parameter int CHAR_W     = 7,
  parameter int ROM_CHAR_W = 6,
  parameter int ROW_COUNT  = 8,
  parameter int DATA_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHAR_W-1:0]                din,
  input  logic                             wr_en,
  input  logic                             clear,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             pause,
  input  logic                             loop,
  input  logic                             invert,
  output logic [ROM_CHAR_W-1:0]            rom_char,
  output logic [$clog2(ROW_COUNT)-1:0]     rom_row,
  input  logic [DATA_W-1:0]                rom_data,
  output logic [DATA_W-1:0]                dout,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             full,
  output logic [$clog2(WORD_COUNT+1)-1:0]  length
);

  localparam int ROW_W = $clog2(ROW_COUNT);
  localparam int LEN_W = $clog2(WORD_COUNT + 1);
  localparam int IDX_W = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state;
  logic [CHAR_W-1:0] mem [WORD_COUNT];
  logic [CHAR_W-1:0] cur_char;
  logic [IDX_W-1:0]  char_idx;
  logic [ROW_W-1:0]  row;
  logic              start_go;
  logic              wr_go;
  logic              last_row;
  logic              last_char;

  always_comb begin
    start_go  = start && !stop && (length != '0);
    wr_go     = (state == IDLE) && wr_en && !clear && !start_go && !full;
    last_row  = (row == ROW_W'(ROW_COUNT - 1));
    last_char = (LEN_W'(char_idx) == length - LEN_W'(1));
  end

  assign cur_char = mem[char_idx];
  assign rom_char = cur_char[ROM_CHAR_W-1:0];
  assign rom_row  = row;
  assign full     = (length == LEN_W'(WORD_COUNT));
  assign busy     = (state == PLAY);
  assign done     = (state == DONE);

  generate
    if (CHAR_W > ROM_CHAR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^cur_char[CHAR_W-1:ROM_CHAR_W];
    end
  endgenerate

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_go) mem[length[IDX_W-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      length     <= '0;
      char_idx   <= '0;
      row        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            state    <= PLAY;
            char_idx <= '0;
            row      <= '0;
          end else if (clear) begin
            length <= '0;
          end else if (wr_go) begin
            length <= length + LEN_W'(1);
          end
        end
        PLAY: begin
          if (stop) begin
            state <= IDLE;
          end else if (!pause) begin
            dout       <= rom_data ^ {DATA_W{invert}};
            dout_valid <= 1'b1;
            if (!last_row) begin
              row <= row + ROW_W'(1);
            end else begin
              row <= '0;
              if (last_char) begin
                char_idx <= '0;
                if (!loop) state <= DONE;
              end else begin
                char_idx <= char_idx + IDX_W'(1);
              end
            end
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state    <= PLAY;
            char_idx <= '0;
            row      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
